// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the pipelined add/sub unit.
// Latency: none (package only).
// Backpressure: not applicable.
package add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef logic op_t;

  // Per-beat result flags; they travel with the result through the pipe.
  typedef struct packed {
    logic co0;
    logic co1;
    logic v;
  } flags_t;

  // Two's-complement overflow of s = a + b, judged from the sign bits only.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_cin.sv
// Carry-in adder: O = I0 + I1 + CIN, with the carry out of the top bit.
// Latency: combinational.
// Backpressure: not applicable.
module add_cin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);

  logic [WIDTH:0] sum;

  assign sum  = {1'b0, I0} + {1'b0, I1} + {{WIDTH{1'b0}}, CIN};
  assign O    = sum[WIDTH-1:0];
  assign COUT = sum[WIDTH];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined O = (A op0 B) op1 C with carry/overflow flags; SUB done as x + ~y + 1.
// Latency: LAT cycles from accept to result (stage1 op0, stage2 op1, rest delay only).
// Backpressure: global stall; every stage holds while out_valid & !out_ready, in_ready = advance.
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  op_t              op0,
  input  op_t              op1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             CO0,
  output logic             CO1,
  output logic             V
);

  typedef struct packed {
    logic             valid;
    op_t              op1;
    logic             co0;
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] c;
  } s1_t;

  typedef struct packed {
    logic             valid;
    flags_t           fl;
    logic [WIDTH-1:0] o;
  } res_t;

  logic             adv;
  s1_t              s1_q, s1_d;
  res_t             s2_q, s2_d;
  res_t             tap [0:LAT-2];   // tap[0] = stage2, tap[LAT-2] = output stage

  logic [WIDTH-1:0] b_x, c_x, r0_w, o_w;
  logic             co0_w, co1_w;

  // The whole pipe moves only when the output slot is empty or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign b_x = (op0 == OP_SUB) ? ~B : B;
  assign c_x = (s1_q.op1 == OP_SUB) ? ~s1_q.c : s1_q.c;

  add_cin #(.WIDTH(WIDTH)) u_stage1 (
    .I0   (A),
    .I1   (b_x),
    .CIN  (op0 == OP_SUB),
    .O    (r0_w),
    .COUT (co0_w)
  );

  add_cin #(.WIDTH(WIDTH)) u_stage2 (
    .I0   (s1_q.r0),
    .I1   (c_x),
    .CIN  (s1_q.op1 == OP_SUB),
    .O    (o_w),
    .COUT (co1_w)
  );

  // Stage1 next state: capture op0 result on an accepted beat; data holds across bubbles.
  always_comb begin
    s1_d = s1_q;
    if (adv) begin
      s1_d.valid = in_valid;
      if (in_valid) begin
        s1_d.op1 = op1;
        s1_d.co0 = co0_w;
        s1_d.r0  = r0_w;
        s1_d.c   = C;
      end
    end
  end

  // Stage2 next state: op1 result and flags; CO0 rides along with its own beat.
  always_comb begin
    s2_d = s2_q;
    if (adv) begin
      s2_d.valid = s1_q.valid;
      if (s1_q.valid) begin
        s2_d.o      = o_w;
        s2_d.fl.co0 = s1_q.co0;
        s2_d.fl.co1 = co1_w;
        s2_d.fl.v   = signed_ovf(s1_q.r0[WIDTH-1], c_x[WIDTH-1], o_w[WIDTH-1]);
      end
    end
  end

  // Stage1/stage2 registers with synchronous reset that drops every in-flight beat.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign tap[0] = s2_q;

  for (genvar k = 1; k < LAT - 1; k++) begin : g_dly
    res_t dly_q;

    // Delay-only stage: follows the previous stage; result fields keep the last valid beat.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        dly_q <= '0;
      end else if (adv) begin
        if (tap[k-1].valid) begin
          dly_q <= tap[k-1];
        end else begin
          dly_q.valid <= 1'b0;
        end
      end
    end

    assign tap[k] = dly_q;
  end

  assign out_valid = tap[LAT-2].valid;
  assign O         = tap[LAT-2].o;
  assign CO0       = tap[LAT-2].fl.co0;
  assign CO1       = tap[LAT-2].fl.co1;
  assign V         = tap[LAT-2].fl.v;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed vectors, backpressure, reset flush, LAT=4 latency, random traffic.
// Latency: checks exact LAT for LAT=2 and LAT=4 instances.
// Backpressure: random out_ready with hold/ordering checked against a queue model.
module tb_pipelined_add_sub;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         in_valid = 1'b0, in_valid4 = 1'b0;
  logic         out_ready = 1'b1, out_ready4 = 1'b1;
  logic [W-1:0] A = '0, B = '0, C = '0;
  logic         op0 = 1'b0, op1 = 1'b0;

  logic         in_ready, out_valid, CO0, CO1, V;
  logic [W-1:0] O;
  logic         in_ready4, out_valid4, CO04, CO14, V4;
  logic [W-1:0] O4;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipelined_add_sub #(.WIDTH(W), .LAT(2)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .op0(op0), .op1(op1),
    .out_valid(out_valid), .out_ready(out_ready),
    .O(O), .CO0(CO0), .CO1(CO1), .V(V)
  );

  pipelined_add_sub #(.WIDTH(W), .LAT(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(A), .B(B), .C(C), .op0(op0), .op1(op1),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .O(O4), .CO0(CO04), .CO1(CO14), .V(V4)
  );

  typedef struct {
    logic [W-1:0] a, b, c;
    logic         op0, op1;
    logic [W-1:0] o;
    logic         co0, co1, v;
  } vec_t;

  vec_t vecs [7];

  // Scoreboard state for the LAT=2 instance
  logic [10:0] q [$];
  logic        held;
  logic [10:0] held_val;
  logic        have_last;
  logic [10:0] last_val;
  int          pops;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {v, co1, co0, o} from plain integer arithmetic.
  function automatic logic [10:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c, input logic p0, input logic p1);
    logic [W-1:0] r0, o;
    logic         c0, c1, v;
    int           sr, sc, so;
    if (p0) begin
      c0 = (a >= b);
      r0 = W'(a - b);
    end else begin
      c0 = (int'(a) + int'(b)) > 255;
      r0 = W'(a + b);
    end
    sr = int'($signed(r0));
    sc = int'($signed(c));
    if (p1) begin
      c1 = (r0 >= c);
      o  = W'(r0 - c);
      so = sr - sc;
    end else begin
      c1 = (int'(r0) + int'(c)) > 255;
      o  = W'(r0 + c);
      so = sr + sc;
    end
    v = (so > 127) || (so < -128);
    return {v, c1, c0, o};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    step();
    RESET = 1'b1;
    in_valid = 1'b0;
    in_valid4 = 1'b0;
    out_ready = 1'b1;
    out_ready4 = 1'b1;
    step();
    step();
    RESET = 1'b0;
    q.delete();
    held = 1'b0;
    held_val = '0;
    have_last = 1'b1;
    last_val = '0;
  endtask

  // Called once per cycle after inputs are driven: handshake bookkeeping on the LAT=2 instance.
  task automatic observe();
    logic [10:0] got, exp;
    #1;
    got = {V, CO1, CO0, O};
    chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
    if (held) chk("hold", int'({out_valid, got}), int'({1'b1, held_val}));
    if (!out_valid && have_last) chk("bubble_hold", int'(got), int'(last_val));
    if (out_valid) begin
      last_val = got;
      have_last = 1'b1;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        exp = q.pop_front();
        chk("result", int'(got), int'(exp));
        pops++;
      end
    end
    held = out_valid && !out_ready;
    held_val = got;
    if (in_valid && in_ready) q.push_back(model(A, B, C, op0, op1));
  endtask

  // One isolated beat; checks exact latency and all result fields.
  task automatic run_vec(input vec_t v, input bit use4, input int exp_lat);
    int n;
    bit seen;
    step();
    A = v.a; B = v.b; C = v.c; op0 = v.op0; op1 = v.op1;
    out_ready = 1'b1;
    out_ready4 = 1'b1;
    if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_valid4 = 1'b0;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 10) begin
      #1;
      if (use4 ? out_valid4 : out_valid) begin
        seen = 1'b1;
        chk("latency", n, exp_lat);
        chk("vec_O",   int'(use4 ? O4 : O),     int'(v.o));
        chk("vec_CO0", int'(use4 ? CO04 : CO0), int'(v.co0));
        chk("vec_CO1", int'(use4 ? CO14 : CO1), int'(v.co1));
        chk("vec_V",   int'(use4 ? V4 : V),     int'(v.v));
      end else begin
        step();
        n++;
      end
    end
    if (!seen) chk("latency_timeout", 0, 1);
  endtask

  initial begin
    int  k;
    bit  saw_out;

    vecs[0] = '{8'h10, 8'h20, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'h00, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h01, 8'h00, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h00, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b1};

    // Reset state, idle
    do_reset();
    step();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_O",         int'(O), 0);
    chk("rst_flags",     int'({CO0, CO1, V}), 0);
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_out_valid4", int'(out_valid4), 0);
    chk("rst_in_ready4", int'(in_ready4), 1);

    // Directed vectors, LAT=2
    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0, 2);

    // Same first vector through the LAT=4 instance
    do_reset();
    run_vec(vecs[0], 1'b1, 4);

    // Backpressure: 4 beats with O = 1..4 while the consumer is stalled
    do_reset();
    pops = 0;
    k = 1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      out_ready = 1'b0;
      A = W'(k); B = '0; C = '0; op0 = 1'b0; op1 = 1'b0;
      in_valid = (k <= 4);
      observe();
      if (in_valid && in_ready) k++;
    end
    chk("bp_accepted", k - 1, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_head_O", int'(O), 1);
    for (int cyc = 0; cyc < 20 && pops < 4; cyc++) begin
      step();
      out_ready = 1'b1;
      A = W'(k);
      in_valid = (k <= 4);
      observe();
      if (in_valid && in_ready) k++;
    end
    chk("bp_count", pops, 4);
    chk("bp_queue_empty", q.size(), 0);

    // Reset with beats in flight (LAT=2): beat in stage1, second beat presented with RESET
    do_reset();
    step();
    A = 8'h11; B = 8'h01; C = '0; op0 = 1'b0; op1 = 1'b0;
    in_valid = 1'b1;
    step();
    A = 8'h22;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_flush_valid", int'(out_valid), 0);
    chk("rst_flush_O", int'(O), 0);
    saw_out = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      #1;
      if (out_valid) saw_out = 1'b1;
    end
    chk("rst_flush_no_out", int'(saw_out), 0);

    // Reset with two beats inside the LAT=4 instance
    do_reset();
    step();
    A = 8'h05; B = 8'h03; C = 8'h01; op0 = 1'b0; op1 = 1'b0;
    in_valid4 = 1'b1;
    step();
    A = 8'h06;
    step();
    in_valid4 = 1'b0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    saw_out = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      #1;
      if (out_valid4) saw_out = 1'b1;
    end
    chk("rst_flush4_no_out", int'(saw_out), 0);

    // Random traffic with random backpressure against the queue model
    do_reset();
    pops = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      A   = W'($urandom);
      B   = W'($urandom);
      C   = W'($urandom);
      op0 = 1'($urandom);
      op1 = 1'($urandom);
      observe();
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      observe();
    end
    chk("rand_drain_empty", q.size(), 0);
    chk("rand_some_output", int'(pops > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
